// File: rtl/noc_pkg.sv
// noc_pkg: shared flit-format constants and FSM state types for the NoC
// router input stage.
//   FLIT_* : one-hot flit id codes carried in flit[ID_LSB +: ID_W]
//   LEN_*  : position/width of the packet length field in a header flit
//   rd_state_e / wr_state_e : read-side and write-side packet FSM states
package noc_pkg;

  localparam int ID_LSB  = 0;
  localparam int ID_W    = 3;
  localparam int LEN_LSB = 3;
  localparam int LEN_W   = 12;

  localparam logic [ID_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [ID_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [ID_W-1:0] FLIT_TAIL   = 3'b100;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_ACTIVE = 1'b1
  } rd_state_e;

  typedef enum logic {
    WR_IDLE   = 1'b0,
    WR_IN_PKT = 1'b1
  } wr_state_e;

endpackage

// File: rtl/noc_fifo_mem.sv
// noc_fifo_mem: DEPTH x DATA_W flit storage, synchronous write, asynchronous
// read. No pointer or flow-control logic here; the owner drives addresses.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module noc_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset; readers qualify with the empty flag.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port router input stage. Buffers flits in a FIFO,
// decodes the head flit and presents request/id/length to the output arbiter.
// Pops one flit per cycle while grant is high.
//   clk, rst   : clock, asynchronous active-high reset
//   in_flit/in_valid/in_ready : upstream flit handshake
//   grant      : this port's arbiter grant bit
//   out_flit/out_valid : head flit to crossbar, FIFO non-empty
//   req, flit_id, length : arbiter request, head id, current packet length
//   occupancy  : stored flit count
//   err        : sticky protocol error
// Build option: define NOC_INBUF_FLITCHECK_EN to add a write-side packet
// checker that drops malformed flits and raises err.
module noc_input_buffer
  import noc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_flit,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   grant,
  output logic [DATA_W-1:0]      out_flit,
  output logic                   out_valid,
  output logic                   req,
  output logic [2:0]             flit_id,
  output logic [11:0]            length,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              full, empty, push, pop, wr_en;
  logic [DATA_W-1:0] head;
  logic [ID_W-1:0]   head_id;
  logic [LEN_W-1:0]  len_q;
  rd_state_e         rd_state, rd_next;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = grant && out_valid;
  assign occupancy = wr_ptr - rd_ptr;

  noc_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_flit),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

`ifdef NOC_INBUF_FLITCHECK_EN
  wr_state_e wr_state, wr_next;
  logic      flit_ok, err_q;

  always_comb begin
    wr_next = wr_state;
    flit_ok = 1'b0;
    case (in_flit[ID_LSB +: ID_W])
      FLIT_HEADER: if (wr_state == WR_IDLE) begin
        flit_ok = 1'b1;
        wr_next = WR_IN_PKT;
      end
      FLIT_BODY: if (wr_state == WR_IN_PKT) flit_ok = 1'b1;
      FLIT_TAIL: if (wr_state == WR_IN_PKT) begin
        flit_ok = 1'b1;
        wr_next = WR_IDLE;
      end
      default: flit_ok = 1'b0;
    endcase
  end

  // Offending flits are still handshaken upstream so the link never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      err_q    <= 1'b0;
    end else if (push) begin
      if (flit_ok) wr_state <= wr_next;
      else         err_q    <= 1'b1;
    end
  end

  assign wr_en = push && flit_ok;
  assign err   = err_q;
`else
  assign wr_en = push;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign head_id = head[ID_LSB +: ID_W];

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE:   if (pop && head_id == FLIT_HEADER) rd_next = RD_ACTIVE;
      RD_ACTIVE: if (pop && head_id == FLIT_TAIL)   rd_next = RD_IDLE;
      default:   rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_state <= RD_IDLE;
    else     rd_state <= rd_next;
  end

  // len_q captures the header length so it survives the header's pop; while
  // a header sits at the head its field is forwarded directly so the arbiter
  // sees the length in the same cycle as the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     len_q <= '0;
    else if (out_valid && head_id == FLIT_HEADER) len_q <= head[LEN_LSB +: LEN_W];
  end

  assign length   = (out_valid && head_id == FLIT_HEADER) ? head[LEN_LSB +: LEN_W] : len_q;
  assign out_flit = out_valid ? head : '0;
  assign flit_id  = out_valid ? head_id : '0;
  assign req      = out_valid && (rd_state == RD_ACTIVE || head_id == FLIT_HEADER);

endmodule

// File: tb/tb_noc_input_buffer.sv
// tb_noc_input_buffer: scoreboard bench for noc_input_buffer. Accepted flits
// are queued as they are driven; the head outputs are compared against the
// queue front every cycle and entries are popped as grants consume them.
module tb_noc_input_buffer;
  import noc_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_flit = '0;
  logic        in_valid = 1'b0;
  logic        grant = 1'b0;
  logic        in_ready, out_valid, req, err;
  logic [31:0] out_flit;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [3:0]  occupancy;

  noc_input_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .grant     (grant),
    .out_flit  (out_flit),
    .out_valid (out_valid),
    .req       (req),
    .flit_id   (flit_id),
    .length    (length),
    .occupancy (occupancy),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] sb[$];
  logic        active  = 1'b0;
  logic [11:0] exp_len = '0;
  logic        exp_err = 1'b0;
  logic        in_pkt  = 1'b0;

  function automatic logic [31:0] hdr(input logic [11:0] len, input logic [16:0] p);
    return {p, len, FLIT_HEADER};
  endfunction
  function automatic logic [31:0] body(input logic [28:0] p);
    return {p, FLIT_BODY};
  endfunction
  function automatic logic [31:0] tail(input logic [28:0] p);
    return {p, FLIT_TAIL};
  endfunction

  task automatic clear_model();
    sb.delete();
    active  = 1'b0;
    exp_len = '0;
    exp_err = 1'b0;
    in_pkt  = 1'b0;
  endtask

  // Called just after a clock edge with inputs already driven: compare head
  // outputs against the model, then advance one edge.
  task automatic step();
    logic [31:0] hd, f;
    logic        exp_req, acc, pp, legal;
    int          n;
    n  = sb.size();
    hd = '0;
    if (n != 0) hd = sb[0];
    exp_req = (n != 0) && (active || hd[2:0] == FLIT_HEADER);
    if (n != 0 && hd[2:0] == FLIT_HEADER) exp_len = hd[14:3];

    n_assert++; if (in_ready !== (n < DEPTH)) begin n_fail++; $display("FAIL in_ready: got %0b expected %0b", in_ready, (n < DEPTH)); end
    n_assert++; if (out_valid !== (n != 0)) begin n_fail++; $display("FAIL out_valid: got %0b expected %0b", out_valid, (n != 0)); end
    n_assert++; if (occupancy !== 4'(n)) begin n_fail++; $display("FAIL occupancy: got %0d expected %0d", occupancy, n); end
    n_assert++; if (out_flit !== hd) begin n_fail++; $display("FAIL out_flit: got %h expected %h", out_flit, hd); end
    n_assert++; if (flit_id !== hd[2:0]) begin n_fail++; $display("FAIL flit_id: got %b expected %b", flit_id, hd[2:0]); end
    n_assert++; if (req !== exp_req) begin n_fail++; $display("FAIL req: got %0b expected %0b", req, exp_req); end
    n_assert++; if (length !== exp_len) begin n_fail++; $display("FAIL length: got %0d expected %0d", length, exp_len); end
    n_assert++; if (err !== exp_err) begin n_fail++; $display("FAIL err: got %0b expected %0b", err, exp_err); end

    acc   = in_valid && (n < DEPTH);
    legal = 1'b1;
`ifdef NOC_INBUF_FLITCHECK_EN
    case (in_flit[2:0])
      FLIT_HEADER: legal = !in_pkt;
      FLIT_BODY:   legal = in_pkt;
      FLIT_TAIL:   legal = in_pkt;
      default:     legal = 1'b0;
    endcase
    if (acc && legal) begin
      if (in_flit[2:0] == FLIT_HEADER) in_pkt = 1'b1;
      if (in_flit[2:0] == FLIT_TAIL)   in_pkt = 1'b0;
    end
    if (acc && !legal) exp_err = 1'b1;
`endif
    pp = grant && (n != 0);
    @(posedge clk);
    if (pp) begin
      f = sb.pop_front();
      if (!active && f[2:0] == FLIT_HEADER)     active = 1'b1;
      else if (active && f[2:0] == FLIT_TAIL)   active = 1'b0;
    end
    if (acc && legal) sb.push_back(in_flit);
    #1;
  endtask

  task automatic cyc(input logic [31:0] f, input logic v, input logic g);
    in_flit  = f;
    in_valid = v;
    grant    = g;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; grant = 1'b0;
    @(posedge clk); #1;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    n_assert++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b expected 0", req); end
    n_assert++; if (flit_id !== 3'b000) begin n_fail++; $display("FAIL reset_flit_id: got %b expected 000", flit_id); end
    n_assert++; if (length !== 12'd0) begin n_fail++; $display("FAIL reset_length: got %0d expected 0", length); end
    n_assert++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", err); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    n_assert++; if (out_flit !== 32'd0) begin n_fail++; $display("FAIL reset_out_flit: got %h expected 0", out_flit); end
    rst = 1'b0;
    clear_model();
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic test_packet();
    cyc(hdr(12'd5, 17'h1abc), 1'b1, 1'b0);
    cyc(body(29'h123), 1'b1, 1'b0);
    cyc(tail(29'h456), 1'b1, 1'b0);
    in_valid = 1'b0;
    n_assert++; if (occupancy !== 4'd3) begin n_fail++; $display("FAIL pkt_occupancy: got %0d expected 3", occupancy); end
    n_assert++; if (req !== 1'b1) begin n_fail++; $display("FAIL pkt_req: got %0b expected 1", req); end
    n_assert++; if (flit_id !== FLIT_HEADER) begin n_fail++; $display("FAIL pkt_flit_id: got %b expected 001", flit_id); end
    n_assert++; if (length !== 12'd5) begin n_fail++; $display("FAIL pkt_length: got %0d expected 5", length); end
    for (int i = 0; i < 3; i++) cyc('0, 1'b0, 1'b1);
    grant = 1'b0;
    n_assert++; if (req !== 1'b0) begin n_fail++; $display("FAIL pkt_req_after_tail: got %0b expected 0", req); end
    n_assert++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL pkt_fsm_idle: got %0d expected %0d", dut.rd_state, RD_IDLE); end
  endtask

  task automatic test_empty_grant();
    cyc(hdr(12'd3, 17'h5), 1'b1, 1'b1);
    n_assert++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL empty_grant_occupancy: got %0d expected 1", occupancy); end
    n_assert++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL empty_grant_fsm: got %0d expected %0d", dut.rd_state, RD_IDLE); end
    cyc(tail(29'h9), 1'b1, 1'b1);
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic test_full();
    cyc(hdr(12'd8, 17'h77), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(body(29'(32'h100 + i)), 1'b1, 1'b0);
    cyc(tail(29'h1ff), 1'b1, 1'b0);
    n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %0b expected 0", in_ready); end
    n_assert++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occupancy: got %0d expected 8", occupancy); end
    cyc(hdr(12'd9, 17'h99), 1'b1, 1'b1);
    in_valid = 1'b0; grant = 1'b0;
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %0b expected 1", in_ready); end
    n_assert++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL full_occupancy_after_pop: got %0d expected 7", occupancy); end
    for (int i = 0; i < 7; i++) cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic test_stream();
    cyc(hdr(12'd20, 17'h2a), 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 19) cyc(tail(29'h3000), 1'b1, 1'b1);
      else         cyc(body(29'(32'h2000 + i * 3)), 1'b1, 1'b1);
      n_assert++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL stream_occupancy[%0d]: got %0d expected 1", i, occupancy); end
    end
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic test_grant_drop();
    cyc(hdr(12'd777, 17'h4), 1'b1, 1'b0);
    cyc(body(29'h51), 1'b1, 1'b0);
    cyc(body(29'h52), 1'b1, 1'b0);
    cyc(tail(29'h53), 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      cyc('0, 1'b0, 1'b0);
      n_assert++; if (req !== 1'b1) begin n_fail++; $display("FAIL drop_req: got %0b expected 1", req); end
      n_assert++; if (length !== 12'd777) begin n_fail++; $display("FAIL drop_length: got %0d expected 777", length); end
      n_assert++; if (flit_id !== FLIT_BODY) begin n_fail++; $display("FAIL drop_flit_id: got %b expected 010", flit_id); end
      n_assert++; if (dut.rd_state !== RD_ACTIVE) begin n_fail++; $display("FAIL drop_fsm: got %0d expected %0d", dut.rd_state, RD_ACTIVE); end
    end
    for (int i = 0; i < 3; i++) cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic test_rst_mid();
    cyc(hdr(12'd44, 17'h6), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(body(29'(32'h600 + i)), 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b1);
    n_assert++; if (occupancy !== 4'd4) begin n_fail++; $display("FAIL rst_mid_pre_occupancy: got %0d expected 4", occupancy); end
    n_assert++; if (dut.rd_state !== RD_ACTIVE) begin n_fail++; $display("FAIL rst_mid_pre_fsm: got %0d expected %0d", dut.rd_state, RD_ACTIVE); end
    grant = 1'b0;
    rst = 1'b1;
    #2;
    n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_valid: got %0b expected 0", out_valid); end
    n_assert++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %0b expected 0", req); end
    n_assert++; if (flit_id !== 3'b000) begin n_fail++; $display("FAIL rst_mid_flit_id: got %b expected 000", flit_id); end
    n_assert++; if (length !== 12'd0) begin n_fail++; $display("FAIL rst_mid_length: got %0d expected 0", length); end
    n_assert++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL rst_mid_occupancy: got %0d expected 0", occupancy); end
    n_assert++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %0b expected 1", in_ready); end
    n_assert++; if (out_flit !== 32'd0) begin n_fail++; $display("FAIL rst_mid_out_flit: got %h expected 0", out_flit); end
    n_assert++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL rst_mid_fsm: got %0d expected %0d", dut.rd_state, RD_IDLE); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    cyc('0, 1'b0, 1'b0);
  endtask

  task automatic test_flitcheck();
    cyc(body(29'h77), 1'b1, 1'b0);
    in_valid = 1'b0;
`ifdef NOC_INBUF_FLITCHECK_EN
    n_assert++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL chk_drop_occupancy: got %0d expected 0", occupancy); end
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_err_set: got %0b expected 1", err); end
    cyc(hdr(12'd2, 17'h1), 1'b1, 1'b0);
    cyc({29'h5, 3'b111}, 1'b1, 1'b0);
    cyc(tail(29'h2), 1'b1, 1'b0);
    cyc('0, 1'b0, 1'b0);
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL chk_err_sticky: got %0b expected 1", err); end
    n_assert++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL chk_legal_occupancy: got %0d expected 2", occupancy); end
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
`else
    n_assert++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL nochk_occupancy: got %0d expected 1", occupancy); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL nochk_err: got %0b expected 0", err); end
    n_assert++; if (req !== 1'b0) begin n_fail++; $display("FAIL nochk_req: got %0b expected 0", req); end
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
    n_assert++; if (dut.rd_state !== RD_IDLE) begin n_fail++; $display("FAIL nochk_fsm: got %0d expected %0d", dut.rd_state, RD_IDLE); end
`endif
  endtask

  initial begin
    test_reset();
    test_packet();
    test_empty_grant();
    test_full();
    test_stream();
    test_grant_drop();
    test_rst_mid();
    test_flitcheck();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
